swa_weight_ctrl: RTL and testbench

//  Weighted-round-robin epoch controller for the combined VC/SW allocator.
//  - Counts switch grants per input VC and per input port.
//  - Drives vc_weight_is_consumed_all / iport_weight_is_consumed_all, so the allocator

---
 rtl/pronoc_pkg.sv | 18 +
 rtl/swa_weight_cnt.sv | 82 ++++++++
 rtl/swa_weight_ctrl.sv | 95 +++++++++
 tb/tb_swa_weight_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pronoc_pkg.sv
// Shared router configuration for the weighted-round-robin allocator support logic.
package pronoc_pkg;

    localparam int WEIGHTw = 4;

    typedef enum logic [1:0] {W_IDLE, W_SERVE, W_EXHAUSTED} wrr_state_t;

    // VCs per port for each NoC instance
    function automatic int noc_conf_v(input int noc_id);
        return (noc_id == 1) ? 4 : 2;
    endfunction

    // A zero weight still grants one packet/flit per epoch
    function automatic logic [WEIGHTw-1:0] eff_weight(input logic [WEIGHTw-1:0] w);
        return (w == '0) ? WEIGHTw'(1) : w;
    endfunction

endpackage

// File: rtl/swa_weight_cnt.sv
// Per-port epoch budget: IDLE/SERVE/EXHAUSTED FSM plus a saturating grant counter.
module swa_weight_cnt
    import pronoc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_refresh,
    input  logic               i_req,
    input  logic               i_grant,
    input  logic [WEIGHTw-1:0] i_weight,
    output logic               o_exhausted,
    output logic               o_consumed
);

    wrr_state_t         r_state, w_state_n;
    logic [WEIGHTw-1:0] r_cnt, w_cnt_n;
    logic               r_consumed;
    logic [WEIGHTw-1:0] w_eff;
    logic [WEIGHTw-1:0] w_cnt_dec;

    // Next-state: a grant that lands on a refresh opens the new epoch immediately
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_eff     = eff_weight(i_weight);
        w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - WEIGHTw'(1);
        if (i_refresh) begin
            if (i_grant) begin
                w_state_n = (w_eff == WEIGHTw'(1)) ? W_EXHAUSTED : W_SERVE;
                w_cnt_n   = w_eff - WEIGHTw'(1);
            end else begin
                w_state_n = W_IDLE;
                w_cnt_n   = '0;
            end
        end else begin
            case (r_state)
                W_IDLE: begin
                    if (i_grant) begin
                        w_state_n = (w_eff == WEIGHTw'(1)) ? W_EXHAUSTED : W_SERVE;
                        w_cnt_n   = w_eff - WEIGHTw'(1);
                    end
                end
                W_SERVE: begin
                    if (i_grant) begin
                        w_cnt_n = w_cnt_dec;
                        // the grant that empties the budget closes this port's epoch
                        if (r_cnt <= WEIGHTw'(1))
                            w_state_n = W_EXHAUSTED;
                    end else if (!i_req) begin
                        w_state_n = W_IDLE;
                        w_cnt_n   = '0;
                    end
                end
                W_EXHAUSTED: begin
                    if (i_grant)
                        w_cnt_n = w_cnt_dec;
                end
                default: begin
                    w_state_n = W_IDLE;
                    w_cnt_n   = '0;
                end
            endcase
        end
    end

    // State, counter and registered consumed flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= W_IDLE;
            r_cnt      <= '0;
            r_consumed <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_consumed <= (w_state_n == W_EXHAUSTED);
        end
    end

    assign o_exhausted = (r_state == W_EXHAUSTED);
    assign o_consumed  = r_consumed;

endmodule

// File: rtl/swa_weight_ctrl.sv
// WRR epoch controller: per-IVC packet budgets, per-port budgets and epoch refresh.
module swa_weight_ctrl
    import pronoc_pkg::*;
#(
    parameter  int NOC_ID = 0,
    parameter  int P      = 5,
    localparam int V      = noc_conf_v(NOC_ID)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [P*V-1:0]         ivc_request_all,
    input  logic [P*V-1:0]         ivc_num_getting_sw_grant,
    input  logic [P*V-1:0]         ivc_hdr_granted_all,
    input  logic [P*V*WEIGHTw-1:0] ivc_hdr_weight_all,
    input  logic [P*WEIGHTw-1:0]   iport_weight_all,
    output logic [P*V-1:0]         vc_weight_is_consumed_all,
    output logic [P-1:0]           iport_weight_is_consumed_all,
    output logic                   epoch_refresh
);

    logic [P-1:0]       w_port_req, w_port_gnt, w_port_exh, w_port_consumed;
    logic               w_refresh_cond;
    logic               r_refresh;

    logic [WEIGHTw-1:0] r_vc_cnt   [P*V];
    logic [WEIGHTw-1:0] w_vc_cnt_n [P*V];
    logic [P*V-1:0]     r_vc_busy, w_vc_busy_n;
    logic [P*V-1:0]     r_vc_consumed, w_vc_consumed_n;

    genvar gp;
    generate
        for (gp = 0; gp < P; gp++) begin : g_port
            assign w_port_req[gp] = |ivc_request_all[gp*V +: V];
            assign w_port_gnt[gp] = |ivc_num_getting_sw_grant[gp*V +: V];

            swa_weight_cnt u_cnt (
                .clk         (clk),
                .reset       (reset),
                .i_refresh   (r_refresh),
                .i_req       (w_port_req[gp]),
                .i_grant     (w_port_gnt[gp]),
                .i_weight    (iport_weight_all[gp*WEIGHTw +: WEIGHTw]),
                .o_exhausted (w_port_exh[gp]),
                .o_consumed  (w_port_consumed[gp])
            );
        end
    endgenerate

    // Refresh once every requesting port is exhausted; the pulse itself masks a repeat
    // while ports are still leaving EXHAUSTED
    always_comb begin
        w_refresh_cond = (|w_port_exh) && (&(w_port_exh | ~w_port_req)) && !r_refresh;
    end

    // Refresh pulse register
    always_ff @(posedge clk) begin
        if (reset) r_refresh <= 1'b0;
        else       r_refresh <= w_refresh_cond;
    end

    // Per-IVC next state: header grant reloads the packet budget, flits drain it
    always_comb begin
        for (int i = 0; i < P*V; i++) begin
            w_vc_cnt_n[i]  = r_vc_cnt[i];
            w_vc_busy_n[i] = r_vc_busy[i] && !r_refresh;
            if (ivc_num_getting_sw_grant[i]) begin
                if (ivc_hdr_granted_all[i]) begin
                    w_vc_cnt_n[i]  = eff_weight(ivc_hdr_weight_all[i*WEIGHTw +: WEIGHTw]) - WEIGHTw'(1);
                    w_vc_busy_n[i] = 1'b1;
                end else if (r_vc_cnt[i] != '0) begin
                    w_vc_cnt_n[i] = r_vc_cnt[i] - WEIGHTw'(1);
                end
            end
            w_vc_consumed_n[i] = (w_vc_cnt_n[i] == '0) && w_vc_busy_n[i];
        end
    end

    // Per-IVC counters and registered consumed flags
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < P*V; i++) r_vc_cnt[i] <= '0;
            r_vc_busy     <= '0;
            r_vc_consumed <= '0;
        end else begin
            for (int i = 0; i < P*V; i++) r_vc_cnt[i] <= w_vc_cnt_n[i];
            r_vc_busy     <= w_vc_busy_n;
            r_vc_consumed <= w_vc_consumed_n;
        end
    end

    assign vc_weight_is_consumed_all    = r_vc_consumed;
    assign iport_weight_is_consumed_all = w_port_consumed;
    assign epoch_refresh                = r_refresh;

endmodule

// File: tb/tb_swa_weight_ctrl.sv
// Directed bench: stimulus pushes hand-computed expected outputs, a monitor pops and checks.
module tb_swa_weight_ctrl;
    import pronoc_pkg::*;

    localparam int P = 5;
    localparam int V = noc_conf_v(0);
    localparam int W = WEIGHTw;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [P*V-1:0]   req = '0, gnt = '0, hdr = '0;
    logic [P*V*W-1:0] hw = '1;
    logic [P*W-1:0]   pw = '1;
    logic [P*V-1:0]   vc_out;
    logic [P-1:0]     port_out;
    logic             ref_out;

    typedef struct {
        int             cyc;
        string          name;
        logic [P*V-1:0] vc;
        logic [P-1:0]   port;
        logic           refr;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    swa_weight_ctrl #(.NOC_ID(0), .P(P)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .ivc_request_all              (req),
        .ivc_num_getting_sw_grant     (gnt),
        .ivc_hdr_granted_all          (hdr),
        .ivc_hdr_weight_all           (hw),
        .iport_weight_all             (pw),
        .vc_weight_is_consumed_all    (vc_out),
        .iport_weight_is_consumed_all (port_out),
        .epoch_refresh                (ref_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due in this cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            if (vc_out !== e.vc || port_out !== e.port || ref_out !== e.refr) begin
                n_fail++;
                $display("FAIL %s: got vc=%b port=%b ref=%b, want vc=%b port=%b ref=%b",
                         e.name, vc_out, port_out, ref_out, e.vc, e.port, e.refr);
            end
        end
    end

    function automatic logic [P*V-1:0] bitv(input int p, input int v);
        logic [P*V-1:0] b;
        b = '0;
        b[p*V+v] = 1'b1;
        return b;
    endfunction

    task automatic step(input logic [P*V-1:0] r, input logic [P*V-1:0] g, input logic [P*V-1:0] h);
        req = r; gnt = g; hdr = h;
        @(posedge clk); #1;
    endtask

    task automatic expect_out(input string n, input logic [P*V-1:0] v, input logic [P-1:0] p, input logic r);
        exp_t e;
        e.cyc = cyc; e.name = n; e.vc = v; e.port = p; e.refr = r;
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step('0, '0, '0);
        reset = 1'b0;
        hw = '1;
        pw = '1;
    endtask

    logic [P*V-1:0] r01, rp;

    initial begin
        // reset with live traffic
        pw[0*W +: W] = W'(1);
        reset = 1'b1;
        step('1, bitv(0,0), bitv(0,0));
        expect_out("reset_a", '0, '0, 1'b0);
        step('1, bitv(0,0), bitv(0,0));
        expect_out("reset_b", '0, '0, 1'b0);
        reset = 1'b0; hw = '1; pw = '1;
        step('0, '0, '0);
        expect_out("post_reset", '0, '0, 1'b0);

        // port 0 weight 3, port 1 also requesting
        pw[0*W +: W] = W'(3);
        r01 = bitv(0,0) | bitv(1,0);
        step(r01, bitv(0,0), bitv(0,0));
        expect_out("w3_g1", '0, 5'b00000, 1'b0);
        step(r01, bitv(0,0), '0);
        expect_out("w3_g2", '0, 5'b00000, 1'b0);
        step(r01, bitv(0,0), '0);
        expect_out("w3_g3", '0, 5'b00001, 1'b0);
        step(r01, '0, '0);
        expect_out("w3_hold", '0, 5'b00001, 1'b0);
        // reset mid-operation with grants present: no refresh pulse
        reset = 1'b1;
        step(r01, bitv(0,0), bitv(0,0));
        expect_out("mid_reset", '0, '0, 1'b0);
        reset = 1'b0; hw = '1; pw = '1;

        // port 3 weight 0 -> treated as 1
        pw[3*W +: W] = '0;
        hw[7*W +: W] = W'(5);
        rp = bitv(3,1);
        step(rp, rp, rp);
        expect_out("w0_single", '0, 5'b01000, 1'b0);
        step(rp, '0, '0);
        expect_out("w0_refresh", '0, 5'b01000, 1'b1);
        step(rp, '0, '0);
        expect_out("w0_after_ref", '0, 5'b00000, 1'b0);
        step(rp, '0, '0);
        expect_out("w0_quiet", '0, 5'b00000, 1'b0);
        do_reset();

        // ports 0 and 1, weight 2 each, both exhaust -> refresh
        pw[0*W +: W] = W'(2);
        pw[1*W +: W] = W'(2);
        step(r01, bitv(0,0), bitv(0,0));
        expect_out("two_a", '0, 5'b00000, 1'b0);
        step(r01, bitv(0,0), '0);
        expect_out("two_b", '0, 5'b00001, 1'b0);
        step(r01, bitv(1,0), bitv(1,0));
        expect_out("two_c", '0, 5'b00001, 1'b0);
        step(r01, bitv(1,0), '0);
        expect_out("two_d", '0, 5'b00011, 1'b0);
        step(r01, '0, '0);
        expect_out("two_refresh", '0, 5'b00011, 1'b1);
        step(r01, '0, '0);
        expect_out("two_drop", '0, 5'b00000, 1'b0);
        do_reset();

        // IVC (port 2, vc 1) header weight 4
        hw[5*W +: W] = W'(4);
        rp = bitv(2,1);
        step(rp, rp, rp);
        expect_out("vc_hdr", '0, '0, 1'b0);
        step(rp, rp, '0);
        expect_out("vc_f1", '0, '0, 1'b0);
        step(rp, rp, '0);
        expect_out("vc_f2", '0, '0, 1'b0);
        step(rp, rp, '0);
        expect_out("vc_f3_consumed", rp, '0, 1'b0);
        step(rp, rp, '0);
        expect_out("vc_saturate", rp, '0, 1'b0);
        step(rp, rp, rp);
        expect_out("vc_new_hdr", '0, '0, 1'b0);
        do_reset();

        // refresh coincides with a grant on port 2 (weight 2)
        pw[0*W +: W] = W'(1);
        pw[2*W +: W] = W'(2);
        step(bitv(0,0), bitv(0,0), bitv(0,0));
        expect_out("co_p0_exh", '0, 5'b00001, 1'b0);
        step(bitv(0,0), '0, '0);
        expect_out("co_refresh", '0, 5'b00001, 1'b1);
        step(bitv(0,0) | bitv(2,0), bitv(2,0), bitv(2,0));
        expect_out("co_new_epoch", '0, 5'b00000, 1'b0);
        step(bitv(0,0) | bitv(2,0), bitv(2,0), '0);
        expect_out("co_p2_exh", '0, 5'b00100, 1'b0);
        do_reset();

        // port 1 in SERVE drops its requests: budget forfeited
        pw[1*W +: W] = W'(3);
        rp = bitv(1,0);
        step(rp, rp, rp);
        expect_out("drop_g1", '0, '0, 1'b0);
        step('0, '0, '0);
        expect_out("drop_idle", '0, '0, 1'b0);
        step('0, '0, '0);
        expect_out("drop_no_ref", '0, '0, 1'b0);
        step(rp, rp, rp);
        expect_out("drop_g2", '0, '0, 1'b0);
        step(rp, rp, '0);
        expect_out("drop_g3", '0, '0, 1'b0);
        step(rp, rp, '0);
        expect_out("drop_g4_exh", '0, 5'b00010, 1'b0);

        // let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
